// File: rtl/seg7_capture_if.sv
// Multiplexed 7-segment bus plus recovered-digit outputs for seg7_capture.
// SEG7CAP_DP_EN adds the decimal-point line and per-digit dp outputs.
interface seg7_capture_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic              clr;
  logic [4*NDIG-1:0] bcd;
  logic              valid;
  logic              err;
`ifdef SEG7CAP_DP_EN
  logic              dp;
  logic [NDIG-1:0]   dp_out;

  modport master (
    output seg, dig_sel, clr, dp,
    input  bcd, valid, err, dp_out
  );
  modport slave (
    input  seg, dig_sel, clr, dp,
    output bcd, valid, err, dp_out
  );
`else
  modport master (
    output seg, dig_sel, clr,
    input  bcd, valid, err
  );
  modport slave (
    input  seg, dig_sel, clr,
    output bcd, valid, err
  );
`endif
endinterface

// File: rtl/seg7_capture.sv
// Recovers BCD digits from a multiplexed 7-segment display bus.
// Optional decimal-point capture is enabled with SEG7CAP_DP_EN.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input logic clk,
  input logic rst_n,
  seg7_capture_if.slave bus
);
  localparam logic [3:0] STB = 4'(STABLE);

  logic [6:0]        s_seg;
  logic [NDIG-1:0]   s_sel;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [NDIG-1:0]   mask;
  logic [NDIG-1:0]   mbase;
  logic [4*NDIG-1:0] shadow;
  logic [4*NDIG-1:0] bcd_q;
  logic              done;
  logic              valid_q;
  logic              err_q;
  logic              onehot;
  logic              same;
  logic              acc;
  logic              bad;
  logic              full;
  logic [3:0]        nib;
`ifdef SEG7CAP_DP_EN
  logic              s_dp;
  logic [NDIG-1:0]   dps;
  logic [NDIG-1:0]   dp_q;
`endif

  always_comb begin
    onehot = (bus.dig_sel != '0) &&
             ((bus.dig_sel & (bus.dig_sel - 1'b1)) == '0);
    same = ({bus.seg, bus.dig_sel} == {s_seg, s_sel});
`ifdef SEG7CAP_DP_EN
    same = same && (bus.dp == s_dp);
`endif
    cnt_nx = 4'd1;
    if (!onehot)
      cnt_nx = 4'd0;
    else if (same)
      cnt_nx = (cnt >= STB) ? STB : cnt + 4'd1;
    // accept only on the transition into STABLE, never while held
    acc = onehot && (cnt_nx == STB) && !(same && cnt == STB);
    mbase = done ? '0 : mask;
    full = ((mbase | bus.dig_sel) == '1);
  end

  always_comb begin
    bad = 1'b0;
    nib = 4'hE;
    case (bus.seg)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b0000000: nib = 4'hF;
      default:    bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg   <= '0;
      s_sel   <= '0;
      cnt     <= '0;
      mask    <= '0;
      shadow  <= '0;
      bcd_q   <= '0;
      done    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEG7CAP_DP_EN
      s_dp    <= 1'b0;
      dps     <= '0;
      dp_q    <= '0;
`endif
    end else begin
      s_seg   <= bus.seg;
      s_sel   <= bus.dig_sel;
      cnt     <= cnt_nx;
      valid_q <= done;
      if (done)
        bcd_q <= shadow;
      for (int i = 0; i < NDIG; i++)
        if (acc && bus.dig_sel[i])
          shadow[4*i +: 4] <= nib;
      if (bus.clr) begin
        mask  <= '0;
        done  <= 1'b0;
        err_q <= 1'b0;
      end else begin
        mask  <= acc ? (mbase | bus.dig_sel) : mbase;
        done  <= acc && full;
        err_q <= err_q | (acc & bad);
      end
`ifdef SEG7CAP_DP_EN
      s_dp <= bus.dp;
      if (done)
        dp_q <= dps;
      for (int i = 0; i < NDIG; i++)
        if (acc && bus.dig_sel[i])
          dps[i] <= bus.dp;
`endif
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
`ifdef SEG7CAP_DP_EN
  assign bus.dp_out = dp_q;
`endif
endmodule
